// File: rtl/jpeg_output_arb.sv
// jpeg_output_arb
//   Round-robin burst arbiter that merges the Y/Cb/Cr requester FIFOs into a
//   single output beat stream. A grant lasts up to BURST beats or until the
//   granted FIFO runs dry. Changing grants costs one IDLE cycle. The output
//   is a one-entry skid-free register that can be reloaded in the same cycle
//   it is accepted.
//
// Ports
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   flush_i           synchronous abort of arbitration and output stage
//   req_valid_i       per-requester FIFO non-empty
//   req_data_i        per-requester FIFO head, requester r at [r*WIDTH +: WIDTH]
//   req_pop_o         per-requester pop strobe (one-hot or zero)
//   outport_valid_o   output beat valid
//   outport_data_o    output beat data
//   outport_src_o     requester index that supplied the beat
//   outport_last_o    final beat of a full BURST-length grant
//   outport_accept_i  downstream ready
//   busy_o            transfer in progress or output beat pending
module jpeg_output_arb #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 3,
  parameter int SRC_W   = 2,
  parameter int BURST   = 8,
  parameter int CNT_W   = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_pop_o,
  output logic                     outport_valid_o,
  output logic [WIDTH-1:0]         outport_data_o,
  output logic [SRC_W-1:0]         outport_src_o,
  output logic                     outport_last_o,
  input  logic                     outport_accept_i,
  output logic                     busy_o
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state_q;
  logic [SRC_W-1:0] grant_q;
  logic [SRC_W-1:0] last_q;
  logic [CNT_W-1:0] beat_q;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SRC_W-1:0] src_p1;
  logic             last_p1;

  logic [SRC_W-1:0] next_grant;
  logic [SRC_W-1:0] hi_idx;
  logic [SRC_W-1:0] lo_idx;
  logic             hi_found;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             space;
  logic             pop;
  logic             last_beat;

  // Round-robin search: the lowest valid index above last_q wins; if none
  // exists, wrap to the lowest valid index overall (which may be last_q).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int r = NUM_REQ - 1; r >= 0; r--) begin
      if (req_valid_i[r]) begin
        lo_idx = SRC_W'(r);
        if (SRC_W'(r) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = SRC_W'(r);
        end
      end
    end
    next_grant = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_q == SRC_W'(r)) begin
        sel_valid = req_valid_i[r];
        sel_data  = req_data_i[r*WIDTH +: WIDTH];
      end
    end
  end

  assign space     = ~vld_p1 | outport_accept_i;
  assign last_beat = (beat_q == CNT_W'(BURST - 1));
  // Reset and flush suppress the pop so no FIFO entry is consumed in a
  // cycle whose beat would be thrown away.
  assign pop       = (state_q == XFER) & ~rst_i & ~flush_i & sel_valid & space;

  always_comb begin
    req_pop_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_pop_o[r] = pop & (grant_q == SRC_W'(r));
    end
  end

  // ---- stage p0 -> p1: arbitration state and output register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= SRC_W'(NUM_REQ - 1);
      beat_q  <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      last_p1 <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= SRC_W'(NUM_REQ - 1);
      beat_q  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            grant_q <= next_grant;
            beat_q  <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (space) begin
            if (sel_valid) begin
              beat_q <= beat_q + 1'b1;
              if (last_beat) begin
                last_q  <= grant_q;
                state_q <= IDLE;
              end
            end else begin
              // Granted FIFO ran dry: end the grant early without a beat.
              last_q  <= grant_q;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (pop) begin
        vld_p1  <= 1'b1;
        data_p1 <= sel_data;
        src_p1  <= grant_q;
        last_p1 <= last_beat;
      end else if (outport_accept_i) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign outport_valid_o = vld_p1;
  assign outport_data_o  = data_p1;
  assign outport_src_o   = src_p1;
  assign outport_last_o  = last_p1;
  assign busy_o          = (state_q == XFER) | vld_p1;

endmodule

// File: tb/tb_jpeg_output_arb.sv
module tb_jpeg_output_arb;
  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 3;
  localparam int SRC_W   = 2;
  localparam int BURST   = 8;
  localparam int CNT_W   = 3;

  typedef logic [WIDTH-1:0] beat_t;

  logic                     clk = 1'b0;
  logic                     rst_i;
  logic                     flush_i;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_pop_o;
  logic                     outport_valid_o;
  logic [WIDTH-1:0]         outport_data_o;
  logic [SRC_W-1:0]         outport_src_o;
  logic                     outport_last_o;
  logic                     outport_accept_i;
  logic                     busy_o;

  always #5 clk = ~clk;

  jpeg_output_arb #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .SRC_W(SRC_W), .BURST(BURST), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_pop_o(req_pop_o),
    .outport_valid_o(outport_valid_o),
    .outport_data_o(outport_data_o),
    .outport_src_o(outport_src_o),
    .outport_last_o(outport_last_o),
    .outport_accept_i(outport_accept_i),
    .busy_o(busy_o)
  );

  // Requester FIFO models and per-source expected output order.
  beat_t fifo_q[NUM_REQ][$];
  beat_t exp_q[NUM_REQ][$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [NUM_REQ-1:0] en;
  logic               acc;
  logic               rand_acc;

  int log_src[$];
  int log_last[$];
  int log_cyc[$];

  logic [NUM_REQ-1:0] s_pop;
  logic               s_vld;
  logic [WIDTH-1:0]   s_data;
  logic [SRC_W-1:0]   s_src;
  logic               s_last;
  logic               s_busy;

  logic [WIDTH-1:0]   h_data;
  logic [SRC_W-1:0]   h_src;
  logic               h_last;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit all_empty();
    for (int r = 0; r < NUM_REQ; r++) if (fifo_q[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    for (int r = 0; r < NUM_REQ; r++) begin
      req_valid_i[r] = en[r] && (fifo_q[r].size() > 0);
      if (fifo_q[r].size() > 0) req_data_i[r*WIDTH +: WIDTH] = fifo_q[r][0];
      else                      req_data_i[r*WIDTH +: WIDTH] = '0;
    end
    outport_accept_i = rand_acc ? ($urandom_range(0, 3) != 0) : acc;
  endtask

  // One clock: sample at the falling edge, apply FIFO pops after the rising
  // edge, then drive the next cycle's inputs.
  task automatic step();
    @(negedge clk);
    s_pop  = req_pop_o;
    s_vld  = outport_valid_o;
    s_data = outport_data_o;
    s_src  = outport_src_o;
    s_last = outport_last_o;
    s_busy = busy_o;
    check("pop_onehot", 32'($countones(s_pop) <= 1), 1);
    check("pop_when_invalid", 32'((s_pop & ~req_valid_i) == '0), 1);
    if (s_vld && outport_accept_i) begin
      log_src.push_back(int'(s_src));
      log_last.push_back(int'(s_last));
      log_cyc.push_back(cyc);
      if (int'(s_src) >= NUM_REQ || exp_q[s_src].size() == 0)
        check("sb_unexpected_beat", {24'd0, s_data}, 32'hFFFF_FFFF);
      else
        check("sb_data", {24'd0, s_data}, {24'd0, exp_q[s_src].pop_front()});
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < NUM_REQ; r++)
      if (s_pop[r] && fifo_q[r].size() > 0) void'(fifo_q[r].pop_front());
    drive_inputs();
  endtask

  task automatic fill(input int r, input int n, input int base, input bit rnd);
    beat_t v;
    for (int i = 0; i < n; i++) begin
      v = rnd ? beat_t'($urandom) : beat_t'(base + i);
      fifo_q[r].push_back(v);
      exp_q[r].push_back(v);
    end
  endtask

  task automatic clear_log();
    log_src.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  task automatic run_until_log(input int n, input int budget);
    int k = 0;
    while (log_src.size() < n && k < budget) begin
      step();
      k++;
    end
    check("beats_within_budget", log_src.size(), n);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    do begin
      step();
      k++;
    end while (k < budget && (!all_empty() || s_busy));
    check("drain_done", 32'(all_empty() && !s_busy), 1);
    for (int r = 0; r < NUM_REQ; r++) check("sb_leftover", exp_q[r].size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int k;
    rst_i = 1'b1;
    flush_i = 1'b0;
    en = '1;
    acc = 1'b1;
    rand_acc = 1'b0;
    req_valid_i = '0;
    req_data_i = '0;
    outport_accept_i = 1'b1;

    // Reset with a requester already valid: nothing may be popped or emitted.
    fifo_q[0].push_back(8'hAA);
    drive_inputs();
    repeat (3) step();
    check("rst_pop", s_pop, 0);
    check("rst_valid", s_vld, 0);
    check("rst_data", s_data, 0);
    check("rst_src", s_src, 0);
    check("rst_last", s_last, 0);
    check("rst_busy", s_busy, 0);
    fifo_q[0].delete();
    rst_i = 1'b0;
    drive_inputs();
    step();
    check("idle_busy", s_busy, 0);

    // Three requesters with one full burst each.
    clear_log();
    for (int r = 0; r < NUM_REQ; r++) fill(r, 8, 16 * (r + 1), 1'b0);
    drive_inputs();
    t0 = cyc;
    run_until_log(24, 200);
    check("first_beat_latency", log_cyc[0] - t0, 2);
    check("in_burst_rate", log_cyc[1] - log_cyc[0], 1);
    check("gap_0_1", log_cyc[8] - log_cyc[7], 2);
    check("gap_1_2", log_cyc[16] - log_cyc[15], 2);
    for (int i = 0; i < 24; i++) begin
      check("rr_src", log_src[i], i / 8);
      check("rr_last", log_last[i], (i % 8 == 7) ? 1 : 0);
    end
    drain(50);

    // Single requester, 20 beats: bursts of 8, 8, 4.
    clear_log();
    fill(1, 20, 8'h40, 1'b0);
    drive_inputs();
    run_until_log(20, 200);
    check("regrant_gap_a", log_cyc[8] - log_cyc[7], 2);
    check("regrant_gap_b", log_cyc[16] - log_cyc[15], 2);
    for (int i = 0; i < 20; i++) begin
      check("solo_src", log_src[i], 1);
      check("solo_last", log_last[i], (i == 7 || i == 15) ? 1 : 0);
    end
    drain(50);

    // Back-pressure for 5 cycles mid-burst.
    clear_log();
    fill(0, 8, 8'h60, 1'b0);
    drive_inputs();
    run_until_log(3, 50);
    acc = 1'b0;
    drive_inputs();
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_pop", s_pop, 0);
      check("hold_valid", s_vld, 1);
      if (i == 0) begin
        h_data = s_data;
        h_src  = s_src;
        h_last = s_last;
        check("hold_first_data", s_data, 8'h63);
      end else begin
        check("hold_data", s_data, h_data);
        check("hold_src", s_src, h_src);
        check("hold_last", s_last, h_last);
      end
    end
    acc = 1'b1;
    drive_inputs();
    run_until_log(8, 50);
    for (int i = 0; i < 8; i++) check("hold_src_seq", log_src[i], 0);
    check("hold_last_beat", log_last[7], 1);
    drain(50);

    // Flush mid-burst of requester 1 with requester 2 also waiting.
    clear_log();
    fill(1, 8, 8'h80, 1'b0);
    fill(2, 8, 8'hA0, 1'b0);
    drive_inputs();
    run_until_log(3, 50);
    check("pre_flush_src", log_src[0], 1);
    flush_i = 1'b1;
    drive_inputs();
    step();
    check("flush_pop", s_pop, 0);
    flush_i = 1'b0;
    drive_inputs();
    step();
    check("flush_valid_cleared", s_vld, 0);
    check("flush_idle_pop", s_pop, 0);
    k = 0;
    do begin
      step();
      k++;
    end while (s_pop == '0 && k < 20);
    check("flush_regrant", s_pop, 3'b010);
    drain(200);

    // Random valid/accept stress.
    rand_acc = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      en = NUM_REQ'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, NUM_REQ - 1);
        if (fifo_q[k].size() < 8) fill(k, $urandom_range(1, 6), 0, 1'b1);
      end
      step();
    end
    en = '1;
    rand_acc = 1'b0;
    acc = 1'b1;
    drive_inputs();
    drain(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
